// File: rtl/simple_axi_slave_ram_if.sv
// simple_axi_slave_ram_if: single-beat AXI4 AW/W/B/AR/R bundle between a master and the RAM slave.
interface simple_axi_slave_ram_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    modport master (
        output awvalid, awaddr, awsize, wvalid, wlast, wdata, wstrb, bready,
               arvalid, araddr, arsize, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rlast, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, awsize, wvalid, wlast, wdata, wstrb, bready,
               arvalid, araddr, arsize, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rlast, rdata, rresp
    );
endinterface

// File: rtl/simple_axi_slave_ram.sv
// simple_axi_slave_ram: single-beat AXI4 slave over a 64-bit on-chip RAM, one transaction at a time.
// Define SIMPLE_AXI_SLAVE_ALIGN_CHECK_EN to answer misaligned or oversized in-range accesses with SLVERR.
module simple_axi_slave_ram #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    simple_axi_slave_ram_if.slave s_axi
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(8 * DEPTH_WORDS);
`ifdef SIMPLE_AXI_SLAVE_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_RESP, RD_DATA, RD_RESP} state_t;
    state_t state, state_n;

    logic [63:0] mem [DEPTH_WORDS];
    logic        aw_got, w_got, w_last;
    logic [31:0] aw_addr, ar_addr, c_addr;
    logic [2:0]  aw_size, ar_size, c_size;
    logic [63:0] w_data, c_data, rdata;
    logic [7:0]  w_strb, c_strb;
    logic [1:0]  bresp, rresp, wr_resp, rd_resp;
    logic        collect, aw_hs, w_hs, ar_hs, commit, c_last;

    // Addresses below the base wrap to >= 2^32 in 33 bits, so one compare covers both bounds.
    function automatic logic [32:0] offset(input logic [31:0] a);
        return {1'b0, a} - {1'b0, ADDR_BASE};
    endfunction

    function automatic logic hit(input logic [31:0] a);
        return offset(a) < SPAN;
    endfunction

    function automatic logic [IW-1:0] word(input logic [31:0] a);
        return IW'(offset(a) >> 3);
    endfunction

    function automatic logic bad_align(input logic [31:0] a, input logic [2:0] sz);
        return ALIGN_EN && (sz > 3'd3 || (a & ((32'd1 << sz) - 32'd1)) != 32'd0);
    endfunction

    assign collect        = state == IDLE || state == WR_COLLECT;
    assign s_axi.awready  = i_rst_n && collect && !aw_got;
    assign s_axi.wready   = i_rst_n && collect && !w_got;
    assign s_axi.arready  = i_rst_n && state == IDLE && !s_axi.awvalid && !s_axi.wvalid;
    assign aw_hs          = s_axi.awvalid && s_axi.awready;
    assign w_hs           = s_axi.wvalid && s_axi.wready;
    assign ar_hs          = s_axi.arvalid && s_axi.arready;
    assign commit         = collect && (aw_got || aw_hs) && (w_got || w_hs);
    assign c_addr         = aw_got ? aw_addr : s_axi.awaddr;
    assign c_size         = aw_got ? aw_size : s_axi.awsize;
    assign c_data         = w_got ? w_data : s_axi.wdata;
    assign c_strb         = w_got ? w_strb : s_axi.wstrb;
    assign c_last         = w_got ? w_last : s_axi.wlast;
    assign wr_resp        = !hit(c_addr) ? DECERR : (!c_last || bad_align(c_addr, c_size)) ? SLVERR : OKAY;
    assign rd_resp        = !hit(ar_addr) ? DECERR : bad_align(ar_addr, ar_size) ? SLVERR : OKAY;
    assign s_axi.bvalid   = state == WR_RESP;
    assign s_axi.bresp    = bresp;
    assign s_axi.rvalid   = state == RD_RESP;
    assign s_axi.rlast    = state == RD_RESP;
    assign s_axi.rdata    = rdata;
    assign s_axi.rresp    = rresp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, WR_COLLECT: state_n = commit ? WR_RESP : (aw_hs || w_hs) ? WR_COLLECT : ar_hs ? RD_DATA : state;
            WR_RESP:          state_n = s_axi.bready ? IDLE : WR_RESP;
            RD_DATA:          state_n = RD_RESP;
            RD_RESP:          state_n = s_axi.rready ? IDLE : RD_RESP;
            default:          state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_last  <= 1'b0;
            aw_addr <= '0;
            aw_size <= '0;
            ar_addr <= '0;
            ar_size <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp   <= OKAY;
            rresp   <= OKAY;
            rdata   <= '0;
        end else begin
            if (aw_hs) begin
                aw_got  <= 1'b1;
                aw_addr <= s_axi.awaddr;
                aw_size <= s_axi.awsize;
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
                w_last <= s_axi.wlast;
            end
            if (state == WR_RESP && s_axi.bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (commit) bresp <= wr_resp;
            if (ar_hs) begin
                ar_addr <= s_axi.araddr;
                ar_size <= s_axi.arsize;
            end
            if (state == RD_DATA) begin
                rdata <= rd_resp == OKAY ? mem[word(ar_addr)] : '0;
                rresp <= rd_resp;
            end
        end
    end

    // RAM is not reset; handshakes are gated off during reset, so no commit can slip through.
    always_ff @(posedge i_clk) begin
        if (commit && wr_resp == OKAY)
            for (int k = 0; k < 8; k++)
                if (c_strb[k]) mem[word(c_addr)][8*k +: 8] <= c_data[8*k +: 8];
    end
endmodule

// File: tb/tb_simple_axi_slave_ram.sv
// tb_simple_axi_slave_ram: randomized single-beat traffic against a word-array model of the RAM slave.
module tb_simple_axi_slave_ram;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 16;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
`ifdef SIMPLE_AXI_SLAVE_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simple_axi_slave_ram_if s_axi();

    simple_axi_slave_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .s_axi  (s_axi)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] mdl [DEPTH];
    logic [1:0]  qb [$];
    logic [65:0] qr [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] sz, input logic last, input bit wr);
        longint off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= 8 * DEPTH) return DECERR;
        if (wr && !last) return SLVERR;
        if (ALIGN_EN && (sz > 3 || (a % (32'd1 << sz)) != 0)) return SLVERR;
        return OKAY;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic logic rdy(input int c);
        return c == 0 ? s_axi.awready : c == 1 ? s_axi.wready : s_axi.arready;
    endfunction

    // Response checker: every cycle a response is valid it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_axi.bvalid) begin
                chk("b_expected", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) chk("bresp", s_axi.bresp, qb[0]);
                chk("b_readies_idle", {s_axi.awready, s_axi.wready, s_axi.arready}, 0);
            end
            if (s_axi.rvalid) begin
                chk("r_expected", 64'(qr.size() != 0), 64'd1);
                if (qr.size() != 0) begin
                    chk("rresp", s_axi.rresp, qr[0][65:64]);
                    chk("rdata", s_axi.rdata, qr[0][63:0]);
                end
                chk("rlast", s_axi.rlast, 1);
                chk("r_readies_idle", {s_axi.awready, s_axi.wready, s_axi.arready}, 0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (s_axi.bvalid && s_axi.bready && qb.size() != 0) void'(qb.pop_front());
            if (s_axi.rvalid && s_axi.rready && qr.size() != 0) void'(qr.pop_front());
        end
    end

    task automatic wait_rdy(input int c, input string name);
        int n = 0;
        @(negedge clk);
        while (!rdy(c) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_timeout"}, rdy(c), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [2:0] sz, input int dly);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        s_axi.awaddr = a;
        s_axi.awsize = sz;
        s_axi.awvalid = 1'b1;
        wait_rdy(0, "aw");
        s_axi.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic last, input int dly);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        s_axi.wdata = d;
        s_axi.wstrb = st;
        s_axi.wlast = last;
        s_axi.wvalid = 1'b1;
        wait_rdy(1, "w");
        s_axi.wvalid = 1'b0;
    endtask

    // lead > 0: W goes lead cycles before AW; lead < 0: AW goes first.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] st,
                            input logic last, input logic [2:0] sz, input int lead, input int bdly);
        logic [1:0] r = exp_resp(a, sz, last, 1'b1);
        if (r == OKAY)
            for (int k = 0; k < 8; k++)
                if (st[k]) mdl[widx(a)][8*k +: 8] = d[8*k +: 8];
        qb.push_back(r);
        fork
            send_aw(a, sz, lead > 0 ? lead : 0);
            send_w(d, st, last, lead < 0 ? -lead : 0);
        join
        @(negedge clk);
        chk("b_latency", s_axi.bvalid, 1);
        repeat (bdly) @(negedge clk);
        s_axi.bready = 1'b1;
        @(posedge clk);
        #1 s_axi.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input int rdly,
                           output logic [63:0] d, output logic [1:0] r);
        logic [1:0] e = exp_resp(a, sz, 1'b1, 1'b0);
        qr.push_back({e, e == OKAY ? mdl[widx(a)] : 64'd0});
        s_axi.araddr = a;
        s_axi.arsize = sz;
        s_axi.arvalid = 1'b1;
        wait_rdy(2, "ar");
        s_axi.arvalid = 1'b0;
        @(negedge clk);
        chk("r_latency_1", s_axi.rvalid, 0);
        @(negedge clk);
        chk("r_latency_2", s_axi.rvalid, 1);
        d = s_axi.rdata;
        r = s_axi.rresp;
        repeat (rdly) @(negedge clk);
        s_axi.rready = 1'b1;
        @(posedge clk);
        #1 s_axi.rready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, keep;
        logic [1:0]  r;
        logic [31:0] a;
        logic [2:0]  sz;
        {s_axi.awvalid, s_axi.wvalid, s_axi.arvalid, s_axi.bready, s_axi.rready, s_axi.wlast} = '0;
        {s_axi.awaddr, s_axi.araddr, s_axi.awsize, s_axi.arsize, s_axi.wdata, s_axi.wstrb} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readies", {s_axi.awready, s_axi.wready, s_axi.arready}, 0);
        chk("rst_outputs", {s_axi.bvalid, s_axi.bresp, s_axi.rvalid, s_axi.rlast, s_axi.rresp}, 0);
        chk("rst_rdata", s_axi.rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_readies", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
        chk("model_pin_decerr", exp_resp(BASE + 8 * DEPTH, 3'd3, 1'b1, 1'b1), DECERR);
        chk("model_pin_slverr", exp_resp(BASE + 8, 3'd3, 1'b0, 1'b1), SLVERR);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 1'b1, 3'd3, 0, 0);

        do_write(BASE + 32'h10, 64'h1122334455667788, 8'hFF, 1'b1, 3'd3, 0, 0);
        do_read(BASE + 32'h10, 3'd3, 0, d, r);
        chk("tp_full_rdata", d, 64'h1122334455667788);
        chk("tp_full_rresp", r, OKAY);
        do_write(BASE + 32'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b1, 3'd3, 3, 1);
        do_read(BASE + 32'h10, 3'd3, 2, d, r);
        chk("tp_strobe_rdata", d, 64'h11223344_BBBBBBBB);

        keep = mdl[0];
        do_write(BASE + 32'(8 * DEPTH), '1, 8'hFF, 1'b1, 3'd3, -2, 0);
        do_read(BASE, 3'd3, 0, d, r);
        chk("oor_no_alias", d, keep);
        do_read(BASE + 32'(8 * DEPTH), 3'd3, 0, d, r);
        chk("oor_rresp", r, DECERR);
        chk("oor_rdata", d, 0);
        do_read(BASE + 32'(8 * DEPTH - 1), 3'd0, 0, d, r);
        chk("last_byte_rresp", r, OKAY);

        mdl[4] = 64'hCAFE_F00D_1234_5678;
        qb.push_back(OKAY);
        qr.push_back({OKAY, 64'hCAFE_F00D_1234_5678});
        s_axi.awaddr = BASE + 32'h20;
        s_axi.awsize = 3'd3;
        s_axi.wdata = 64'hCAFE_F00D_1234_5678;
        s_axi.wstrb = 8'hFF;
        s_axi.wlast = 1'b1;
        s_axi.araddr = BASE + 32'h20;
        s_axi.arsize = 3'd3;
        {s_axi.awvalid, s_axi.wvalid, s_axi.arvalid} = 3'b111;
        @(negedge clk);
        chk("arb_arready", s_axi.arready, 0);
        chk("arb_aw_w_ready", {s_axi.awready, s_axi.wready}, 2'b11);
        @(posedge clk);
        #1 {s_axi.awvalid, s_axi.wvalid} = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arb_hold_bvalid", s_axi.bvalid, 1);
            chk("arb_hold_arready", s_axi.arready, 0);
        end
        s_axi.bready = 1'b1;
        @(posedge clk);
        #1 s_axi.bready = 1'b0;
        @(negedge clk);
        chk("arb_arready_after_b", s_axi.arready, 1);
        @(posedge clk);
        #1 s_axi.arvalid = 1'b0;
        @(negedge clk);
        chk("arb_r_latency_1", s_axi.rvalid, 0);
        @(negedge clk);
        chk("arb_r_latency_2", s_axi.rvalid, 1);
        chk("arb_rdata", s_axi.rdata, 64'hCAFE_F00D_1234_5678);
        s_axi.rready = 1'b1;
        @(posedge clk);
        #1 s_axi.rready = 1'b0;

        keep = mdl[6];
        s_axi.awaddr = BASE + 32'h30;
        s_axi.awsize = 3'd3;
        s_axi.wdata = ~keep;
        s_axi.wstrb = 8'hFF;
        s_axi.awvalid = 1'b1;
        wait_rdy(0, "rst_aw");
        s_axi.awvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_readies", {s_axi.awready, s_axi.wready, s_axi.arready}, 0);
            chk("rst_mid_bvalid", s_axi.bvalid, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_bvalid", s_axi.bvalid, 0);
            chk("post_rst_awready", s_axi.awready, 1);
        end
        @(posedge clk);
        #1;
        do_read(BASE + 32'h30, 3'd3, 0, d, r);
        chk("rst_word_unchanged", d, keep);

        do_read(BASE + 32'h13, 3'd1, 0, d, r);
        if (ALIGN_EN) begin
            chk("align_rresp", r, SLVERR);
            chk("align_rdata", d, 0);
        end else begin
            chk("align_rresp", r, OKAY);
            chk("align_rdata", d, 64'h11223344_BBBBBBBB);
        end

        repeat (200) begin
            a = BASE + 32'($urandom_range(0, DEPTH + 7)) * 8 + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 7)) : 32'd0);
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd3;
            if ($urandom_range(0, 1) == 1)
                do_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 9) != 0, sz,
                         int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            else
                do_read(a, sz, int'($urandom_range(0, 3)), d, r);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("b_queue_drained", 64'(qb.size()), 0);
        chk("r_queue_drained", 64'(qr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
